// File: rtl/interrupt_sequencer.sv
// Interrupt sequencer: synchronizes an async request, waits for a safe fetch
// boundary, drains fetch, pulses the core interrupt and blocks nesting until RTI.
module interrupt_sequencer #(
  parameter int SETTLE_CYCLES  = 3,
  parameter int SERVICE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       irq_in,
  input  logic       flush,
  input  logic       two_word,
  input  logic       rti_done,
  output logic       interrupt,
  output logic       fetch_hold,
  output logic       busy,
  output logic       pending,
  output logic [7:0] dropped_count
);

  typedef enum logic [2:0] {IDLE, PEND, DRAIN, FIRE, SERVICE, WAIT_RTI} state_t;

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       queued, queued_nxt;
  logic [7:0] drop_nxt;
  logic       s1, s2, s3;
  logic       irq_edge;
  logic       rti_exit;

  assign irq_edge = s2 & ~s3;
  assign rti_exit = (state == WAIT_RTI) && rti_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1            <= 1'b0;
      s2            <= 1'b0;
      s3            <= 1'b0;
      state         <= IDLE;
      cnt           <= '0;
      queued        <= 1'b0;
      dropped_count <= '0;
    end else begin
      s1            <= irq_in;
      s2            <= s1;
      s3            <= s2;
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      queued        <= queued_nxt;
      dropped_count <= drop_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE:     if (irq_edge) state_nxt = PEND;
      PEND:     if (!flush && !two_word) begin
                  state_nxt = DRAIN;
                  cnt_nxt   = 4'(SETTLE_CYCLES - 1);
                end
      DRAIN:    if (cnt == 4'd0) state_nxt = FIRE;
                else cnt_nxt = cnt - 4'd1;
      FIRE:     begin
                  state_nxt = SERVICE;
                  cnt_nxt   = 4'(SERVICE_CYCLES - 1);
                end
      SERVICE:  if (cnt == 4'd0) state_nxt = WAIT_RTI;
                else cnt_nxt = cnt - 4'd1;
      WAIT_RTI: if (rti_done) state_nxt = (queued || irq_edge) ? PEND : IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // On RTI exit a queued request becomes the pending one; a coincident edge
  // refills the queue so neither request is lost.
  always_comb begin
    queued_nxt = queued;
    drop_nxt   = dropped_count;
    if (rti_exit) begin
      queued_nxt = queued & irq_edge;
    end else if (irq_edge && (state == DRAIN || state == FIRE ||
                              state == SERVICE || state == WAIT_RTI)) begin
      if (!queued)                      queued_nxt = 1'b1;
      else if (dropped_count != 8'hff)  drop_nxt   = dropped_count + 8'd1;
    end
  end

  always_comb begin
    interrupt  = (state == FIRE);
    fetch_hold = (state == DRAIN);
    busy       = (state == FIRE) || (state == SERVICE) || (state == WAIT_RTI);
    pending    = (state == PEND) || (state == DRAIN);
  end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Bench for interrupt_sequencer: cycle tables checked through an expected-value
// queue, plus hand sequences for nesting, saturation, reset and RTI/edge overlap.
module tb_interrupt_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       irq_in = 1'b0, flush = 1'b0, two_word = 1'b0, rti_done = 1'b0;
  logic       interrupt, fetch_hold, busy, pending;
  logic [7:0] dropped_count;

  int checks = 0;
  int errors = 0;

  interrupt_sequencer #(.SETTLE_CYCLES(3), .SERVICE_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .irq_in(irq_in), .flush(flush), .two_word(two_word),
    .rti_done(rti_done), .interrupt(interrupt), .fetch_hold(fetch_hold), .busy(busy),
    .pending(pending), .dropped_count(dropped_count)
  );

  always #5 clk = ~clk;

  // outs packing: {interrupt, fetch_hold, busy, pending}
  localparam logic [3:0] O_I = 4'b1000, O_F = 4'b0100, O_B = 4'b0010, O_P = 4'b0001;

  typedef struct {
    logic       irq, fl, tw, rti;
    logic [3:0] outs;
    logic [7:0] drop;
  } vec_t;

  typedef struct {
    logic [3:0] outs;
    logic [7:0] drop;
    int         idx;
  } exp_t;

  vec_t tbl[$];
  exp_t exp_q[$];

  function automatic logic [3:0] outs();
    return {interrupt, fetch_hold, busy, pending};
  endfunction

  function automatic void add(logic irq, logic fl, logic tw, logic rti, logic [3:0] o);
    vec_t v;
    v.irq = irq; v.fl = fl; v.tw = tw; v.rti = rti; v.outs = o; v.drop = 8'd0;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // Drive one cycle of inputs, then sample just after the rising edge.
  task automatic cyc(input logic irq, input logic fl, input logic tw, input logic rti);
    irq_in = irq; flush = fl; two_word = tw; rti_done = rti;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    irq_in = 0; flush = 0; two_word = 0; rti_done = 0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic run_table(input string name);
    exp_t e;
    for (int i = 0; i < tbl.size(); i++) begin
      e.outs = tbl[i].outs; e.drop = tbl[i].drop; e.idx = i;
      irq_in = tbl[i].irq; flush = tbl[i].fl; two_word = tbl[i].tw; rti_done = tbl[i].rti;
      exp_q.push_back(e);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      chk($sformatf("%s[%0d] outs", name, e.idx), 32'(outs()), 32'(e.outs));
      chk($sformatf("%s[%0d] drop", name, e.idx), 32'(dropped_count), 32'(e.drop));
    end
    tbl.delete();
  endtask

  // Steps from PENDING until the pulse; requires exactly 3 hold cycles and a
  // single-cycle pulse. Ends one cycle after the pulse (first SERVICE cycle).
  task automatic wait_fire(input string name, input logic irq);
    int  fh = 0;
    bit  fired = 0;
    for (int i = 0; i < 20 && !fired; i++) begin
      cyc(irq, 0, 0, 0);
      if (interrupt) fired = 1;
      else if (fetch_hold) fh++;
    end
    chk({name, " fired"}, 32'(fired), 32'd1);
    chk({name, " hold cycles"}, fh, 32'd3);
    cyc(irq, 0, 0, 0);
    chk({name, " pulse width"}, 32'(outs()), 32'(O_B));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    do_reset();
    chk("reset outs", 32'(outs()), 32'd0);
    chk("reset drop", 32'(dropped_count), 32'd0);

    // Single request, idle core; rti during SERVICE must be ignored.
    add(1,0,0,0, 0);       add(1,0,0,0, 0);       add(0,0,0,0, O_P);
    add(0,0,0,0, O_F|O_P); add(0,0,0,0, O_F|O_P); add(0,0,0,0, O_F|O_P);
    add(0,0,0,0, O_I|O_B); add(0,0,0,0, O_B);     add(0,0,0,0, O_B);
    add(0,0,0,1, O_B);     add(0,0,0,0, O_B);     add(0,0,0,0, O_B);
    add(0,0,0,1, 0);       add(0,0,0,0, 0);
    run_table("single");

    // Unsafe boundary: two_word, then flush, then a flush during DRAIN.
    do_reset();
    add(1,0,0,0, 0);       add(1,0,0,0, 0);       add(0,0,0,0, O_P);
    for (int i = 0; i < 5; i++) add(0,0,1,0, O_P);
    add(0,1,0,0, O_P);
    add(0,0,0,0, O_F|O_P); add(0,1,0,0, O_F|O_P); add(0,0,1,0, O_F|O_P);
    add(0,0,0,0, O_I|O_B);
    for (int i = 0; i < 5; i++) add(0,0,0,0, O_B);
    add(0,0,0,1, 0);
    run_table("unsafe");

    // Nesting: three edges during SERVICE/WAIT_RTI -> one queued, two dropped.
    do_reset();
    cyc(1,0,0,0); cyc(1,0,0,0);
    repeat (5) cyc(0,0,0,0);
    chk("nest fire", 32'(outs()), 32'(O_I|O_B));
    for (int k = 0; k < 3; k++) begin
      cyc(1,0,0,0); cyc(1,0,0,0); cyc(0,0,0,0); cyc(0,0,0,0);
      if (k == 1) chk("nest drop after 2", 32'(dropped_count), 32'd1);
    end
    chk("nest drop", 32'(dropped_count), 32'd2);
    chk("nest busy", 32'(outs()), 32'(O_B));
    cyc(0,0,0,1);
    chk("nest requeue", 32'(outs()), 32'(O_P));
    wait_fire("nest second", 0);
    repeat (4) cyc(0,0,0,0);
    cyc(0,0,0,1);
    chk("nest idle", 32'(outs()), 32'd0);
    chk("nest drop final", 32'(dropped_count), 32'd2);

    // Saturation: 300 edges while busy, first one queues.
    do_reset();
    cyc(1,0,0,0); cyc(1,0,0,0);
    repeat (5) cyc(0,0,0,0);
    for (int k = 0; k < 300; k++) begin
      cyc(1,0,0,0); cyc(1,0,0,0); cyc(0,0,0,0); cyc(0,0,0,0);
      if (k == 99) chk("sat drop 100", 32'(dropped_count), 32'd99);
    end
    repeat (3) cyc(0,0,0,0);
    chk("sat drop", 32'(dropped_count), 32'd255);
    chk("sat busy", 32'(outs()), 32'(O_B));

    // Reset mid-DRAIN with irq_in still high.
    do_reset();
    cyc(1,0,0,0); cyc(1,0,0,0); cyc(1,0,0,0); cyc(1,0,0,0); cyc(1,0,0,0);
    chk("rst pre drain", 32'(outs()), 32'(O_F|O_P));
    #3 reset = 1'b1;
    #1;
    chk("rst async outs", 32'(outs()), 32'd0);
    chk("rst async drop", 32'(dropped_count), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rst held outs", 32'(outs()), 32'd0);
    end
    reset = 1'b0;
    cyc(1,0,0,0); cyc(1,0,0,0);
    chk("rst no early pend", 32'(outs()), 32'd0);
    cyc(1,0,0,0);
    chk("rst repend", 32'(outs()), 32'(O_P));
    wait_fire("rst refire", 1);
    repeat (4) cyc(1,0,0,0);
    cyc(1,0,0,1);
    chk("rst idle", 32'(outs()), 32'd0);
    repeat (4) cyc(1,0,0,0);
    chk("rst level no retrigger", 32'(outs()), 32'd0);

    // RTI coinciding with an edge while queued: carry one, drop none.
    do_reset();
    cyc(1,0,0,0); cyc(1,0,0,0);
    repeat (5) cyc(0,0,0,0);
    cyc(1,0,0,0); cyc(1,0,0,0); cyc(0,0,0,0); cyc(0,0,0,0);
    cyc(1,0,0,0); cyc(1,0,0,0);
    chk("sim waiting", 32'(outs()), 32'(O_B));
    cyc(0,0,0,1);
    chk("sim pend", 32'(outs()), 32'(O_P));
    chk("sim drop", 32'(dropped_count), 32'd0);
    wait_fire("sim fire2", 0);
    repeat (4) cyc(0,0,0,0);
    cyc(0,0,0,1);
    chk("sim carried", 32'(outs()), 32'(O_P));
    wait_fire("sim fire3", 0);
    repeat (4) cyc(0,0,0,0);
    cyc(0,0,0,1);
    chk("sim final idle", 32'(outs()), 32'd0);
    chk("sim final drop", 32'(dropped_count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
